// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, forward-select encodings and match helper for
// the pipeline hazard controller.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
    } stage_shadow_t;

    // Bubble content loaded into a stage shadow when that stage is flushed.
    localparam stage_shadow_t SHADOW_NONE = '{
        rs1:      5'd0,
        rs2:      5'd0,
        rd:       5'd0,
        regwrite: 1'b0,
        load:     1'b0
    };

    // True when a writer of rd produces the value a reader of rs needs.
    // x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic rd_hit(input logic [4:0] rd,
                                    input logic       regwrite,
                                    input logic [4:0] rs);
        return (regwrite && (rd != 5'd0) && (rd == rs));
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: picks the ALU operand source for one execute-stage operand.
// The M-stage result is younger than the W-stage result, so it wins.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs_e,
    input  logic [4:0] i_rd_m,
    input  logic       i_regwrite_m,
    input  logic [4:0] i_rd_w,
    input  logic       i_regwrite_w,
    output logic [1:0] o_sel
);

    // Priority select: M result, then W result, then register file.
    always_comb begin
        o_sel = FWD_RF;
        if (rd_hit(i_rd_m, i_regwrite_m, i_rs_e)) begin
            o_sel = FWD_M;
        end else if (rd_hit(i_rd_w, i_regwrite_w, i_rs_e)) begin
            o_sel = FWD_W;
        end else begin
            o_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / flush / forwarding control for the five-stage RV32I
// pipeline, driven from private shadow copies of the E, M and W stages.
// Optional build macro HAZARD_FORWARD_EN: enables operand forwarding, so only
// load-use dependencies stall. Without it every RAW dependency on an E or M
// writer stalls until the writer reaches W.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             rs1D,
    input  logic [4:0]             rs2D,
    input  logic [4:0]             rdD,
    input  logic                   regwriteD,
    input  logic                   resultsrcD,
    input  logic                   pcsrcE,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   flushD,
    output logic                   flushE,
    output logic [1:0]             forwardAE,
    output logic [1:0]             forwardBE,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    hz_state_t              r_state;
    hz_state_t              w_state_nxt;
    logic [4:0]             r_m_rd;
    logic                   r_m_regwrite;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [4:0]             w_e_rd;
    logic                   w_e_regwrite;
    logic                   w_hazard;
    logic                   w_stall;
    logic                   w_flush_e;

`ifdef HAZARD_FORWARD_EN
    stage_shadow_t          r_e;
    logic [4:0]             r_w_rd;
    logic                   r_w_regwrite;

    // E shadow: take the decode fields, or a bubble when E is flushed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_e <= SHADOW_NONE;
        end else if (w_flush_e) begin
            r_e <= SHADOW_NONE;
        end else begin
            r_e <= '{rs1: rs1D, rs2: rs2D, rd: rdD,
                     regwrite: regwriteD, load: resultsrcD};
        end
    end

    // W shadow: only forwarding needs to know what is being written back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_rd       <= 5'd0;
            r_w_regwrite <= 1'b0;
        end else begin
            r_w_rd       <= r_m_rd;
            r_w_regwrite <= r_m_regwrite;
        end
    end

    assign w_e_rd       = r_e.rd;
    assign w_e_regwrite = r_e.regwrite;

    // A load's data is not available for forwarding until W, so a consumer
    // directly behind it must wait one cycle.
    assign w_hazard = r_e.load &&
                      (rd_hit(r_e.rd, r_e.regwrite, rs1D) ||
                       rd_hit(r_e.rd, r_e.regwrite, rs2D));

    fwd_sel u_fwd_a (
        .i_rs_e       (r_e.rs1),
        .i_rd_m       (r_m_rd),
        .i_regwrite_m (r_m_regwrite),
        .i_rd_w       (r_w_rd),
        .i_regwrite_w (r_w_regwrite),
        .o_sel        (forwardAE)
    );

    fwd_sel u_fwd_b (
        .i_rs_e       (r_e.rs2),
        .i_rd_m       (r_m_rd),
        .i_regwrite_m (r_m_regwrite),
        .i_rd_w       (r_w_rd),
        .i_regwrite_w (r_w_regwrite),
        .o_sel        (forwardBE)
    );
`else
    logic [4:0]             r_e_rd;
    logic                   r_e_regwrite;
    logic                   w_unused_load;

    // E shadow: only the writer identity matters when nothing is forwarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_e_rd       <= 5'd0;
            r_e_regwrite <= 1'b0;
        end else if (w_flush_e) begin
            r_e_rd       <= 5'd0;
            r_e_regwrite <= 1'b0;
        end else begin
            r_e_rd       <= rdD;
            r_e_regwrite <= regwriteD;
        end
    end

    assign w_e_rd       = r_e_rd;
    assign w_e_regwrite = r_e_regwrite;

    // Every dependency stalls alike, so whether the writer is a load is moot.
    assign w_unused_load = resultsrcD;

    // Any E or M writer feeding decode must reach W (falling-edge write)
    // before the reader may leave D.
    assign w_hazard = rd_hit(r_e_rd, r_e_regwrite, rs1D) ||
                      rd_hit(r_e_rd, r_e_regwrite, rs2D) ||
                      rd_hit(r_m_rd, r_m_regwrite, rs1D) ||
                      rd_hit(r_m_rd, r_m_regwrite, rs2D);

    assign forwardAE = FWD_RF;
    assign forwardBE = FWD_RF;
`endif

    // M shadow: always advances from E.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_m_rd       <= 5'd0;
            r_m_regwrite <= 1'b0;
        end else begin
            r_m_rd       <= w_e_rd;
            r_m_regwrite <= w_e_regwrite;
        end
    end

    // Next-state and stall decision; a taken branch always overrides a stall
    // because the stalled instruction is on the wrong path.
    always_comb begin
        w_state_nxt = HZ_RUN;
        w_stall     = 1'b0;
        case (r_state)
            HZ_RUN: begin
                if (w_hazard && !pcsrcE) begin
                    w_stall     = 1'b1;
                    w_state_nxt = HZ_STALL;
                end else begin
                    w_stall     = 1'b0;
                    w_state_nxt = HZ_RUN;
                end
            end
            HZ_STALL: begin
`ifdef HAZARD_FORWARD_EN
                w_stall     = 1'b0;
                w_state_nxt = HZ_RUN;
`else
                if (w_hazard && !pcsrcE) begin
                    w_stall     = 1'b1;
                    w_state_nxt = HZ_STALL;
                end else begin
                    w_stall     = 1'b0;
                    w_state_nxt = HZ_RUN;
                end
`endif
            end
            default: begin
                w_stall     = 1'b0;
                w_state_nxt = HZ_RUN;
            end
        endcase
    end

    // State register: remembers that the previous cycle was a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= HZ_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Saturating count of cycles in which decode was held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign w_flush_e = w_stall || pcsrcE;

    assign stallF    = w_stall;
    assign stallD    = w_stall;
    assign flushD    = pcsrcE;
    assign flushE    = w_flush_e;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus a randomized instruction stream
// checked against an instruction-level pipeline model.
module tb_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1D, rs2D, rdD;
    logic          regwriteD, resultsrcD, pcsrcE;
    logic          stallF, stallD, flushD, flushE;
    logic [1:0]    forwardAE, forwardBE;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.STALL_CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .rdD        (rdD),
        .regwriteD  (regwriteD),
        .resultsrcD (resultsrcD),
        .pcsrcE     (pcsrcE),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushD     (flushD),
        .flushE     (flushE),
        .forwardAE  (forwardAE),
        .forwardBE  (forwardBE),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } ins_t;

    // Model: which instruction sits in each stage.
    ins_t m_e, m_m, m_w;
    bit   m_prev_stall;
    int   m_cnt;
    int   total = 0;
    int   bad   = 0;

    logic       exp_stall, exp_fd, exp_fe;
    logic [1:0] exp_fa, exp_fb;

    function automatic ins_t nop();
        ins_t n;
        n.rs1 = 5'd0; n.rs2 = 5'd0; n.rd = 5'd0; n.rw = 1'b0; n.ld = 1'b0;
        return n;
    endfunction

    function automatic bit writes(input ins_t p, input logic [4:0] r);
        return p.rw && (p.rd != 5'd0) && (p.rd == r);
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] r);
        if (writes(m_m, r)) return 2'b10;
        if (writes(m_w, r)) return 2'b01;
        return 2'b00;
    endfunction

    // Drive one decode slot and work out what the controller should say.
    task automatic apply(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic rw, input logic ld,
                         input logic pc, input logic rn);
        bit haz;
        @(negedge clk);
        rs1D = a; rs2D = b; rdD = d; regwriteD = rw; resultsrcD = ld;
        pcsrcE = pc; rst_n = rn;
        #1;
`ifdef HAZARD_FORWARD_EN
        haz       = m_e.ld && (writes(m_e, a) || writes(m_e, b));
        exp_stall = haz && !pc && !m_prev_stall;
        exp_fa    = fsel(m_e.rs1);
        exp_fb    = fsel(m_e.rs2);
`else
        haz       = writes(m_e, a) || writes(m_e, b) ||
                    writes(m_m, a) || writes(m_m, b);
        exp_stall = haz && !pc;
        exp_fa    = 2'b00;
        exp_fb    = 2'b00;
`endif
        exp_fd = pc;
        exp_fe = exp_stall || pc;
    endtask

    // Clock edge: move instructions down the model pipeline.
    task automatic commit();
        ins_t nx;
        nx.rs1 = rs1D; nx.rs2 = rs2D; nx.rd = rdD; nx.rw = regwriteD; nx.ld = resultsrcD;
        @(posedge clk);
        if (!rst_n) begin
            m_e = nop(); m_m = nop(); m_w = nop();
            m_prev_stall = 1'b0;
            m_cnt = 0;
        end else begin
            m_w = m_m;
            m_m = m_e;
            m_e = exp_fe ? nop() : nx;
            m_prev_stall = exp_stall;
            if (exp_stall && (m_cnt < (1 << CW) - 1)) m_cnt++;
        end
    endtask

    task automatic do_reset();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        commit();
    endtask

    task automatic test_reset();
        do_reset();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (stallF !== 1'b0) begin bad++; $display("FAIL rst_stallF got=%0b want=0", stallF); end
        total++; if (stallD !== 1'b0) begin bad++; $display("FAIL rst_stallD got=%0b want=0", stallD); end
        total++; if (flushD !== 1'b0) begin bad++; $display("FAIL rst_flushD got=%0b want=0", flushD); end
        total++; if (flushE !== 1'b0) begin bad++; $display("FAIL rst_flushE got=%0b want=0", flushE); end
        total++; if (forwardAE !== 2'b00) begin bad++; $display("FAIL rst_fwdA got=%0b want=00", forwardAE); end
        total++; if (forwardBE !== 2'b00) begin bad++; $display("FAIL rst_fwdB got=%0b want=00", forwardBE); end
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", stall_cnt); end
        commit();
    endtask

    task automatic test_dep_stall();
        do_reset();
`ifdef HAZARD_FORWARD_EN
        // lw x5,0(x0) ; add x6,x5,x1
        apply(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1); commit();
        apply(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        total++; if (stallF !== 1'b1) begin bad++; $display("FAIL lu_stallF got=%0b want=1", stallF); end
        total++; if (stallD !== 1'b1) begin bad++; $display("FAIL lu_stallD got=%0b want=1", stallD); end
        total++; if (flushE !== 1'b1) begin bad++; $display("FAIL lu_flushE got=%0b want=1", flushE); end
        commit();
        apply(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        total++; if (stallD !== 1'b0) begin bad++; $display("FAIL lu_once got=%0b want=0", stallD); end
        total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt); end
        commit();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (forwardAE !== 2'b01) begin bad++; $display("FAIL lu_fwdA got=%0b want=01", forwardAE); end
        total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL lu_cnt2 got=%0d want=1", stall_cnt); end
        commit();
`else
        // add x5,x1,x2 ; add x6,x5,x1 -> two stall cycles
        apply(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1); commit();
        apply(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        total++; if (stallD !== 1'b1) begin bad++; $display("FAIL nf_stall1 got=%0b want=1", stallD); end
        commit();
        apply(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        total++; if (stallD !== 1'b1) begin bad++; $display("FAIL nf_stall2 got=%0b want=1", stallD); end
        total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL nf_cnt1 got=%0d want=1", stall_cnt); end
        commit();
        apply(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        total++; if (stallD !== 1'b0) begin bad++; $display("FAIL nf_release got=%0b want=0", stallD); end
        total++; if (forwardAE !== 2'b00) begin bad++; $display("FAIL nf_fwdA got=%0b want=00", forwardAE); end
        total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL nf_cnt2 got=%0d want=2", stall_cnt); end
        commit();
`endif
    endtask

    task automatic test_alu_fwd();
        do_reset();
        // add x5,x1,x2 ; sub x7,x5,x5
        apply(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1); commit();
        apply(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef HAZARD_FORWARD_EN
        total++; if (stallD !== 1'b0) begin bad++; $display("FAIL alu_nostall got=%0b want=0", stallD); end
        commit();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (forwardAE !== 2'b10) begin bad++; $display("FAIL alu_fwdA got=%0b want=10", forwardAE); end
        total++; if (forwardBE !== 2'b10) begin bad++; $display("FAIL alu_fwdB got=%0b want=10", forwardBE); end
`else
        total++; if (stallD !== 1'b1) begin bad++; $display("FAIL alu_stall got=%0b want=1", stallD); end
        commit();
        apply(5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        total++; if (forwardBE !== 2'b00) begin bad++; $display("FAIL alu_fwdB got=%0b want=00", forwardBE); end
`endif
        commit();
    endtask

    task automatic test_x0();
        do_reset();
        // lw/add into x0 followed by a reader of x0
        apply(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1); commit();
        apply(5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        total++; if (stallD !== 1'b0) begin bad++; $display("FAIL x0_stall got=%0b want=0", stallD); end
        commit();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (forwardAE !== 2'b00) begin bad++; $display("FAIL x0_fwdA got=%0b want=00", forwardAE); end
        total++; if (forwardBE !== 2'b00) begin bad++; $display("FAIL x0_fwdB got=%0b want=00", forwardBE); end
        total++; if (stallD !== 1'b0) begin bad++; $display("FAIL x0_stall2 got=%0b want=0", stallD); end
        commit();
    endtask

    task automatic test_branch_lw();
        do_reset();
        apply(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1); commit();
        apply(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        total++; if (flushD !== 1'b1) begin bad++; $display("FAIL br_flushD got=%0b want=1", flushD); end
        total++; if (flushE !== 1'b1) begin bad++; $display("FAIL br_flushE got=%0b want=1", flushE); end
        total++; if (stallF !== 1'b0) begin bad++; $display("FAIL br_stallF got=%0b want=0", stallF); end
        total++; if (stallD !== 1'b0) begin bad++; $display("FAIL br_stallD got=%0b want=0", stallD); end
        commit();
        apply(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL br_cnt got=%0d want=0", stall_cnt); end
        commit();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        apply(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1); commit();
        apply(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        total++; if (stallD !== 1'b1) begin bad++; $display("FAIL ms_pre got=%0b want=1", stallD); end
        commit();
        apply(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); commit();
        apply(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        total++; if (stallF !== 1'b0) begin bad++; $display("FAIL ms_stallF got=%0b want=0", stallF); end
        total++; if (stallD !== 1'b0) begin bad++; $display("FAIL ms_stallD got=%0b want=0", stallD); end
        total++; if (flushD !== 1'b0) begin bad++; $display("FAIL ms_flushD got=%0b want=0", flushD); end
        total++; if (flushE !== 1'b0) begin bad++; $display("FAIL ms_flushE got=%0b want=0", flushE); end
        total++; if (forwardAE !== 2'b00) begin bad++; $display("FAIL ms_fwdA got=%0b want=00", forwardAE); end
        total++; if (forwardBE !== 2'b00) begin bad++; $display("FAIL ms_fwdB got=%0b want=00", forwardBE); end
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL ms_cnt got=%0d want=0", stall_cnt); end
        commit();
    endtask

    task automatic test_random();
        ins_t cur;
        logic pc, rn;
        bit   held, flushed;
        do_reset();
        cur = nop(); held = 1'b0; flushed = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (flushed) begin
                cur = nop();
            end else if (!held) begin
                cur.rs1 = 5'($urandom_range(0, 3));
                cur.rs2 = 5'($urandom_range(0, 3));
                cur.rd  = 5'($urandom_range(0, 3));
                cur.rw  = ($urandom_range(0, 3) != 0);
                cur.ld  = ($urandom_range(0, 2) == 0);
            end
            pc = ($urandom_range(0, 7) == 0);
            rn = ($urandom_range(0, 199) != 0);
            apply(cur.rs1, cur.rs2, cur.rd, cur.rw, cur.ld, pc, rn);
            total++; if (stallF !== exp_stall) begin bad++; $display("FAIL rnd_stallF cyc=%0d got=%0b want=%0b", i, stallF, exp_stall); end
            total++; if (stallD !== exp_stall) begin bad++; $display("FAIL rnd_stallD cyc=%0d got=%0b want=%0b", i, stallD, exp_stall); end
            total++; if (flushD !== exp_fd) begin bad++; $display("FAIL rnd_flushD cyc=%0d got=%0b want=%0b", i, flushD, exp_fd); end
            total++; if (flushE !== exp_fe) begin bad++; $display("FAIL rnd_flushE cyc=%0d got=%0b want=%0b", i, flushE, exp_fe); end
            total++; if (forwardAE !== exp_fa) begin bad++; $display("FAIL rnd_fwdA cyc=%0d got=%0b want=%0b", i, forwardAE, exp_fa); end
            total++; if (forwardBE !== exp_fb) begin bad++; $display("FAIL rnd_fwdB cyc=%0d got=%0b want=%0b", i, forwardBE, exp_fb); end
            total++; if (stall_cnt !== m_cnt[CW-1:0]) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d want=%0d", i, stall_cnt, m_cnt); end
            held    = exp_stall && rn;
            flushed = exp_fd && rn;
            commit();
        end
    endtask

    initial begin
        rst_n = 1'b0; rs1D = 5'd0; rs2D = 5'd0; rdD = 5'd0;
        regwriteD = 1'b0; resultsrcD = 1'b0; pcsrcE = 1'b0;
        m_e = nop(); m_m = nop(); m_w = nop(); m_prev_stall = 1'b0; m_cnt = 0;
        test_reset();
        test_dep_stall();
        test_alu_fwd();
        test_x0();
        test_branch_lw();
        test_reset_mid_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
